// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer sizing and Gray/binary conversion.
// Pure functions and constants; no state, no latency, no flow control.
package fifo_pkg;

    localparam int ADDRSIZE_DEF = 4;
    localparam int DATASIZE_DEF = 8;

    function automatic int depth(input int addrsize);
        return 1 << addrsize;
    endfunction

    // One extra MSB over the address tells laps apart, so equal pointers mean empty.
    function automatic int ptr_width(input int addrsize);
        return addrsize + 1;
    endfunction

    localparam int DEPTH_DEF   = depth(ADDRSIZE_DEF);
    localparam int PTRSIZE_DEF = ptr_width(ADDRSIZE_DEF);

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Bits above 'width' are ignored; each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int width);
        logic [31:0] masked;
        logic [31:0] b;
        masked = '0;
        b      = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                masked[i] = g[i];
            end
        end
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(masked >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle: memory read port, pointers to/from the write domain and the output handshake.
// master = read controller, slave = memory/write side and consumer.
interface fifo_rd_ctrl_if #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
);
    logic [ADDRSIZE:0]   wptr;
    logic [DATASIZE-1:0] mem_rdata;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic [DATASIZE-1:0] rdata;
    logic                rvalid;
    logic                rready;
    logic [ADDRSIZE:0]   rcount;

    modport master (
        input  wptr, mem_rdata, rready,
        output raddr, rptr, rempty, rdata, rvalid, rcount
    );

    modport slave (
        output wptr, mem_rdata, rready,
        input  raddr, rptr, rempty, rdata, rvalid, rcount
    );
endinterface

// File: rtl/sync_w2r.sv
// Two-flop synchronizer for a Gray pointer; 2-cycle latency, no flow control.
// Instantiated mirrored on the write side for the read pointer.
module sync_w2r #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end
endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read controller with FWFT output register; write-to-rvalid is 4 rclk edges.
// Fetches only when the output register is free or being drained, so rdata holds while stalled.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input logic           rclk,
    input logic           rrst,
    fifo_rd_ctrl_if.master bus
);
    localparam int PW = ptr_width(ADDRSIZE);

    logic [PW-1:0]       rq2_wptr;
    logic [PW-1:0]       rbin;
    logic [PW-1:0]       rbinnext;
    logic [PW-1:0]       rgraynext;
    logic [PW-1:0]       wbin_sync;
    logic [DATASIZE-1:0] mem_word;
    logic                rinc;

    sync_w2r #(.WIDTH(PW)) u_sync_w2r (
        .clk (rclk),
        .rst (rrst),
        .d   (bus.wptr),
        .q   (rq2_wptr)
    );

    always_comb begin
        mem_word  = bus.mem_rdata;
        rinc      = !bus.rempty && (!bus.rvalid || bus.rready);
        rbinnext  = rbin + PW'(rinc);
        rgraynext = PW'(bin2gray(32'(rbinnext)));
        wbin_sync = PW'(gray2bin(32'(rq2_wptr), PW));
    end

    assign bus.raddr = rbin[ADDRSIZE-1:0];

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin       <= '0;
            bus.rptr   <= '0;
            bus.rempty <= 1'b1;
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
            bus.rcount <= '0;
        end else begin
            rbin       <= rbinnext;
            bus.rptr   <= rgraynext;
            bus.rempty <= (rgraynext == rq2_wptr);
            bus.rcount <= wbin_sync - rbinnext;
            // A drain and a fetch in the same cycle keep rvalid high: no bubble.
            if (rinc) begin
                bus.rdata  <= mem_word;
                bus.rvalid <= 1'b1;
            end else if (bus.rvalid && bus.rready) begin
                bus.rvalid <= 1'b0;
            end
        end
    end
endmodule
